// File: rtl/mod_dec_inv_mix_columns.sv
// AES InvMixColumns stage: iterative one-column-per-clock datapath with valid/ready handshakes.
// Define INV_MIXCOL_PARALLEL_EN to compute all four columns in a single BUSY cycle.
module mod_dec_inv_mix_columns (
  input  logic             clk,
  input  logic             resetn,
  input  logic [15:0][7:0] inp_imc,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [15:0][7:0] outp_imc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam int N     = 16;
  localparam int NCOLS = 4;
  localparam logic [1:0] LAST_COL = 2'(NCOLS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          col_q, col_d;
  logic [N-1:0][7:0]   in_q, in_d;
  logic [N-1:0][7:0]   res_q, res_d;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Build the 09/0b/0d/0e multiples from the shared x2/x4/x8 chain.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [3:0][7:0] a, a2, a4, a8, m9, mb, md, me, r;
    a = c;
    for (int i = 0; i < 4; i++) begin
      a2[i] = xtime(a[i]);
      a4[i] = xtime(a2[i]);
      a8[i] = xtime(a4[i]);
      m9[i] = a8[i] ^ a[i];
      mb[i] = a8[i] ^ a2[i] ^ a[i];
      md[i] = a8[i] ^ a4[i] ^ a[i];
      me[i] = a8[i] ^ a4[i] ^ a2[i];
    end
    r[0] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
    r[1] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
    r[2] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
    r[3] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    in_d    = in_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          in_d    = inp_imc;
          col_d   = 2'd0;
          state_d = BUSY;
        end
      end
      BUSY: begin
`ifdef INV_MIXCOL_PARALLEL_EN
        for (int c = 0; c < NCOLS; c++) begin
          res_d[4*c +: 4] = inv_mix_col(in_q[4*c +: 4]);
        end
        state_d = DONE;
`else
        res_d[{col_q, 2'b00} +: 4] = inv_mix_col(in_q[{col_q, 2'b00} +: 4]);
        col_d = col_q + 2'd1;
        if (col_q == LAST_COL) begin
          state_d = DONE;
        end
`endif
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        col_d   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      col_q   <= 2'd0;
      in_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      in_q    <= in_d;
      res_q   <= res_d;
    end
  end

  // Partial results are visible during BUSY; out_valid qualifies them.
  assign outp_imc  = res_q;
  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == BUSY);
  assign out_valid = (state_q == DONE);

endmodule

// File: tb/tb_mod_dec_inv_mix_columns.sv
// Self-checking bench for mod_dec_inv_mix_columns against a GF(2^8) matrix reference model.
module tb_mod_dec_inv_mix_columns;

  logic             clk = 1'b0;
  logic             resetn;
  logic [15:0][7:0] inp_imc;
  logic             in_valid;
  logic             in_ready;
  logic [15:0][7:0] outp_imc;
  logic             out_valid;
  logic             out_ready;
  logic             busy;

  int total = 0;
  int bad   = 0;

`ifdef INV_MIXCOL_PARALLEL_EN
  localparam int EXP_LAT = 1;
`else
  localparam int EXP_LAT = 4;
`endif

  mod_dec_inv_mix_columns dut (
    .clk       (clk),
    .resetn    (resetn),
    .inp_imc   (inp_imc),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .outp_imc  (outp_imc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Carry-less product followed by reduction modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p ^= (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p ^= (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  // Circulant matrix product per column; inv selects InvMixColumns vs MixColumns.
  function automatic logic [127:0] mix_model(input logic [127:0] s, input bit inv);
    logic [7:0] k [4];
    logic [7:0] acc;
    logic [127:0] o;
    if (inv) begin k[0] = 8'h0e; k[1] = 8'h0b; k[2] = 8'h0d; k[3] = 8'h09; end
    else     begin k[0] = 8'h02; k[1] = 8'h03; k[2] = 8'h01; k[3] = 8'h01; end
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int i = 0; i < 4; i++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc ^= gmul(k[(j - i + 4) % 4], s[8*(4*c+j) +: 8]);
        o[8*(4*c+i) +: 8] = acc;
      end
    return o;
  endfunction

  function automatic logic [31:0] col4(input logic [7:0] r0, r1, r2, r3);
    return {r3, r2, r1, r0};
  endfunction

  function automatic logic [127:0] rand_state();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Accept on the next edge, count edges until out_valid, return the result (out_ready assumed 1).
  task automatic run_block(input logic [127:0] st, output logic [127:0] res, output int lat);
    inp_imc  = st;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    res = outp_imc;
    @(posedge clk); #1;
  endtask

  logic [127:0] st, st2, res, held, orig;
  int lat;

  initial begin
    resetn = 1'b0; in_valid = 1'b0; inp_imc = '0; out_ready = 1'b1;
    #2;
    check_val("rst_outp", outp_imc, '0);
    check_val("rst_ovld", out_valid, 1'b0);
    check_val("rst_irdy", in_ready, 1'b1);
    check_val("rst_busy", busy, 1'b0);
    #10 resetn = 1'b1;
    @(posedge clk); #1;

    // Known column vector
    st = {4{col4(8'h8e, 8'h4d, 8'ha1, 8'hbc)}};
    run_block(st, res, lat);
    check_val("known_const", res, {4{col4(8'hdb, 8'h13, 8'h53, 8'h45)}});
    check_val("known_model", res, mix_model(st, 1'b1));
    check_val("known_lat", lat, EXP_LAT);
    check_val("idle_after", in_ready, 1'b1);

    // Mixed columns
    st = {col4(8'h4d, 8'h7e, 8'hbd, 8'hf8), col4(8'hd5, 8'hd5, 8'hd7, 8'hd6),
          col4(8'h01, 8'h01, 8'h01, 8'h01), col4(8'h9f, 8'hdc, 8'h58, 8'h9d)};
    run_block(st, res, lat);
    check_val("mixed_const", res,
              {col4(8'h2d, 8'h26, 8'h31, 8'h4c), col4(8'hd4, 8'hd4, 8'hd4, 8'hd5),
               col4(8'h01, 8'h01, 8'h01, 8'h01), col4(8'hf2, 8'h0a, 8'h22, 8'h5c)});
    check_val("mixed_lat", lat, EXP_LAT);

    // Output stall with a second state pending
    st  = rand_state();
    st2 = rand_state();
    out_ready = 1'b0;
    inp_imc = st; in_valid = 1'b1;
    @(posedge clk); #1;
    inp_imc = st2;
    check_val("stall_busy", busy, 1'b1);
    lat = 0;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    check_val("stall_lat", lat, EXP_LAT);
    held = outp_imc;
    check_val("stall_res", held, mix_model(st, 1'b1));
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check_val("stall_outp", outp_imc, held);
      check_val("stall_ovld", out_valid, 1'b1);
      check_val("stall_irdy", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_val("drain_ovld", out_valid, 1'b0);
    check_val("drain_irdy", in_ready, 1'b1);
    check_val("drain_busy", busy, 1'b0);
    check_val("drain_outp", outp_imc, held);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_val("second_acc", busy, 1'b1);
    lat = 0;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    check_val("second_res", outp_imc, mix_model(st2, 1'b1));
    @(posedge clk); #1;

    // Asynchronous reset mid-operation
    st = rand_state();
    inp_imc = st; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk); #3;
    resetn = 1'b0;
    #1;
    check_val("mid_rst_busy", busy, 1'b0);
    check_val("mid_rst_ovld", out_valid, 1'b0);
    check_val("mid_rst_outp", outp_imc, '0);
    check_val("mid_rst_irdy", in_ready, 1'b1);
    #2 resetn = 1'b1;
    @(posedge clk); #1;
    st = rand_state();
    run_block(st, res, lat);
    check_val("post_rst_res", res, mix_model(st, 1'b1));
    check_val("post_rst_lat", lat, EXP_LAT);

    // Random direct checks
    for (int n = 0; n < 10; n++) begin
      st = rand_state();
      run_block(st, res, lat);
      check_val("rand_model", res, mix_model(st, 1'b1));
    end

    // Round trip through forward MixColumns
    for (int n = 0; n < 100; n++) begin
      orig = rand_state();
      run_block(mix_model(orig, 1'b0), res, lat);
      check_val("round_trip", res, orig);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
